// File: rtl/uop_packer_pkg.sv
// Shared micro-op constants for the uop packer front-end slice.
package uop_packer_pkg;

  localparam int UOP_W      = 24;
  localparam int UOP_OPC_HI = 23;
  localparam int UOP_OPC_LO = 20;
  localparam int IDLE_W     = 8;

  typedef logic [UOP_W-1:0] uop_t;

  localparam uop_t UOP_NOP = 24'h000000;

endpackage

// File: rtl/uop_packer.sv
// Packs a serial micro-op stream into WIDTH-lane groups for the renamer.
// Define UOP_PACKER_TIMEOUT_EN to auto-pad partial groups after TIMEOUT idle cycles.
module uop_packer
  import uop_packer_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [UOP_W-1:0]             uop_in,
  input  logic                         uop_in_valid,
  output logic                         uop_in_ready,
  input  logic                         pad_req,
  output logic [UOP_W*WIDTH-1:0]       group_out,
  output logic                         group_valid,
  input  logic                         group_ready,
  output logic [$clog2(WIDTH+1)-1:0]   group_count
);

  localparam int                CNT_W    = $clog2(WIDTH+1);
  localparam int                LANE_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WIDTH);
  localparam logic [LANE_W-1:0] LANE_TOP = LANE_W'(WIDTH-1);

  logic [WIDTH-1:0][UOP_W-1:0] fill_q, fill_d;
  logic [WIDTH-1:0][UOP_W-1:0] group_out_q, group_out_d;
  logic [WIDTH-1:0][UOP_W-1:0] pad_grp;
  logic [CNT_W-1:0]            cnt_q, cnt_d, cnt_next;
  logic [CNT_W-1:0]            group_count_q, group_count_d;
  logic                        group_valid_q, group_valid_d;
  logic                        pad_pending_q, pad_pending_d;
  logic [LANE_W-1:0]           wr_lane;
  logic                        in_fire;
  logic                        close_req;
  logic                        complete;
  logic                        slot_free;
  logic                        transfer;
  logic                        timeout_hit;

  // Fill-buffer stage: accept, count and decide completion
  assign uop_in_ready = ~rst & ~flush & (cnt_q != CNT_FULL) & ~pad_pending_q;
  assign in_fire      = uop_in_valid & uop_in_ready;
  assign cnt_next     = cnt_q + CNT_W'(in_fire);
  assign wr_lane      = LANE_TOP - LANE_W'(cnt_q);
  assign close_req    = pad_req | timeout_hit;
  assign complete     = (cnt_next == CNT_FULL) |
                        ((close_req | pad_pending_q) & (cnt_next != '0));
  assign slot_free    = ~group_valid_q | group_ready;
  assign transfer     = complete & slot_free & ~flush;

  always_comb begin
    fill_d = fill_q;
    if (in_fire) begin
      fill_d[wr_lane] = uop_in;
    end
    // Lanes below the youngest real micro-op may hold stale data from an older group
    for (int i = 0; i < WIDTH; i++) begin
      pad_grp[i] = (i >= WIDTH - int'(cnt_next)) ? fill_d[i] : UOP_NOP;
    end
  end

  always_comb begin
    cnt_d         = cnt_next;
    pad_pending_d = pad_pending_q;
    group_valid_d = group_valid_q & ~group_ready;
    group_out_d   = group_out_q;
    group_count_d = group_count_q;
    if (transfer) begin
      cnt_d         = '0;
      pad_pending_d = 1'b0;
      group_valid_d = 1'b1;
      group_out_d   = pad_grp;
      group_count_d = cnt_next;
    end else if (close_req & (cnt_next != '0)) begin
      pad_pending_d = 1'b1;
    end
    if (flush) begin
      cnt_d         = '0;
      pad_pending_d = 1'b0;
      group_valid_d = 1'b0;
    end
  end

`ifdef UOP_PACKER_TIMEOUT_EN
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              idle_inc;

  // Fires on the idle cycle that brings the count up to TIMEOUT
  assign idle_inc    = (cnt_q != '0) & ~in_fire & ~pad_pending_q;
  assign timeout_hit = idle_inc & (idle_q == IDLE_LAST);

  always_comb begin
    idle_d = idle_q;
    if (idle_inc) begin
      idle_d = idle_q + IDLE_W'(1);
    end
    if (in_fire | transfer | flush) begin
      idle_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  logic timeout_unused;

  assign timeout_hit    = 1'b0;
  assign timeout_unused = (TIMEOUT != 0);
`endif

  // Output-register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      pad_pending_q <= 1'b0;
      group_valid_q <= 1'b0;
      group_out_q   <= '0;
      group_count_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      pad_pending_q <= pad_pending_d;
      group_valid_q <= group_valid_d;
      group_out_q   <= group_out_d;
      group_count_q <= group_count_d;
    end
  end

  always_ff @(posedge clk) begin
    fill_q <= fill_d;
  end

  assign group_out   = group_out_q;
  assign group_valid = group_valid_q;
  assign group_count = group_count_q;

endmodule

// File: tb/tb_uop_packer.sv
// Self-checking bench for uop_packer: directed scenarios plus a queue-based scoreboard.
module tb_uop_packer;

  localparam int W  = 4;
  localparam int TO = 8;
  localparam int CW = $clog2(W+1);
`ifdef UOP_PACKER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            flush;
  logic [23:0]     uop_in;
  logic            uop_in_valid;
  logic            uop_in_ready;
  logic            pad_req;
  logic [24*W-1:0] group_out;
  logic            group_valid;
  logic            group_ready;
  logic [CW-1:0]   group_count;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  uop_packer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .uop_in       (uop_in),
    .uop_in_valid (uop_in_valid),
    .uop_in_ready (uop_in_ready),
    .pad_req      (pad_req),
    .group_out    (group_out),
    .group_valid  (group_valid),
    .group_ready  (group_ready),
    .group_count  (group_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: accepted micro-ops collect in fill_m; closed groups queue in exp_q
  typedef struct {
    logic [24*W-1:0] data;
    int              n;
  } grp_t;

  grp_t        exp_q[$];
  logic [23:0] fill_m[$];
  int          idle_m = 0;

  task automatic close_group();
    grp_t g;
    g.data = '0;
    for (int i = 0; i < fill_m.size(); i++) g.data[24*(W-1-i) +: 24] = fill_m[i];
    g.n = fill_m.size();
    exp_q.push_back(g);
    fill_m.delete();
    idle_m = 0;
  endtask

  always @(negedge clk) begin
    bit exp_rdy;
    bit fire;
    if (mon_en) begin
      exp_rdy = !rst && !flush && (exp_q.size() < 2);
      total++;
      if (uop_in_ready !== exp_rdy) begin
        bad++;
        $display("FAIL sb_ready t=%0t got=%b exp=%b", $time, uop_in_ready, exp_rdy);
      end
      total++;
      if (group_valid !== (exp_q.size() > 0)) begin
        bad++;
        $display("FAIL sb_valid t=%0t got=%b exp=%b", $time, group_valid, exp_q.size() > 0);
      end
      if (group_valid === 1'b1 && exp_q.size() > 0) begin
        total++;
        if (group_out !== exp_q[0].data || group_count !== CW'(exp_q[0].n)) begin
          bad++;
          $display("FAIL sb_group t=%0t got=%h/%0d exp=%h/%0d", $time, group_out, group_count,
                   exp_q[0].data, exp_q[0].n);
        end
      end
      if (rst || flush) begin
        exp_q.delete();
        fill_m.delete();
        idle_m = 0;
      end else begin
        fire = uop_in_valid && exp_rdy;
        if (group_valid === 1'b1 && group_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (fire) begin
          fill_m.push_back(uop_in);
          idle_m = 0;
        end else if (TO_EN && fill_m.size() > 0) begin
          idle_m++;
        end
        if (fill_m.size() == W ||
            (fill_m.size() > 0 && (pad_req || (TO_EN && idle_m >= TO)))) close_group();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clean();
    flush = 1'b1; uop_in_valid = 1'b0; pad_req = 1'b0;
    step();
    flush = 1'b0;
  endtask

  task automatic send(input logic [23:0] u);
    uop_in = u; uop_in_valid = 1'b1;
    step();
    uop_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; uop_in = '0; uop_in_valid = 1'b0; pad_req = 1'b0; group_ready = 1'b0;
    repeat (2) step();
    mon_en = 1'b1;
    @(negedge clk);
    total++;
    if (uop_in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", uop_in_ready); end
    step();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (group_valid !== 1'b0 || group_out !== '0 || group_count !== '0) begin
      bad++;
      $display("FAIL rst_outputs got=%b/%h/%0d exp=0/0/0", group_valid, group_out, group_count);
    end
    total++;
    if (uop_in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%b exp=1", uop_in_ready); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [23:0] u[4];
    logic [24*W-1:0] want;
    clean();
    group_ready = 1'b1;
    for (int i = 0; i < 4; i++) u[i] = 24'($urandom);
    for (int i = 0; i < 4; i++) begin
      uop_in = u[i]; uop_in_valid = 1'b1;
      @(negedge clk);
      total++;
      if (uop_in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready lane=%0d got=%b exp=1", i, uop_in_ready); end
      step();
    end
    uop_in_valid = 1'b0;
    want = {u[0], u[1], u[2], u[3]};
    @(negedge clk);
    total++;
    if (group_valid !== 1'b1 || group_out !== want || group_count !== CW'(4)) begin
      bad++;
      $display("FAIL b2b_group got=%b/%h/%0d exp=1/%h/4", group_valid, group_out, group_count, want);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [23:0] u[8];
    logic [24*W-1:0] g0, g1;
    clean();
    group_ready = 1'b0;
    for (int i = 0; i < 8; i++) u[i] = 24'($urandom);
    for (int i = 0; i < 8; i++) send(u[i]);
    g0 = {u[0], u[1], u[2], u[3]};
    g1 = {u[4], u[5], u[6], u[7]};
    @(negedge clk);
    total++;
    if (uop_in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b exp=0", uop_in_ready); end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (group_valid !== 1'b1 || group_out !== g0 || group_count !== CW'(4)) begin
        bad++;
        $display("FAIL bp_hold k=%0d got=%b/%h exp=1/%h", k, group_valid, group_out, g0);
      end
      step();
      @(negedge clk);
    end
    group_ready = 1'b1;
    step();
    group_ready = 1'b0;
    @(negedge clk);
    total++;
    if (group_valid !== 1'b1 || group_out !== g1 || group_count !== CW'(4)) begin
      bad++;
      $display("FAIL bp_second got=%b/%h exp=1/%h", group_valid, group_out, g1);
    end
    total++;
    if (uop_in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_reopen got=%b exp=1", uop_in_ready); end
    group_ready = 1'b1;
    step();
  endtask

  task automatic test_pad();
    logic [23:0] a, b, c;
    logic [24*W-1:0] want;
    clean();
    group_ready = 1'b1;
    a = 24'($urandom); b = 24'($urandom); c = 24'($urandom);
    send(a); send(b);
    pad_req = 1'b1;
    step();
    pad_req = 1'b0;
    want = {a, b, 24'h0, 24'h0};
    @(negedge clk);
    total++;
    if (group_valid !== 1'b1 || group_out !== want || group_count !== CW'(2)) begin
      bad++;
      $display("FAIL pad_two got=%b/%h/%0d exp=1/%h/2", group_valid, group_out, group_count, want);
    end
    pad_req = 1'b1;
    step();
    pad_req = 1'b0;
    @(negedge clk);
    total++;
    if (group_valid !== 1'b0) begin bad++; $display("FAIL pad_empty got=%b exp=0", group_valid); end
    send(a); send(b);
    uop_in = c; uop_in_valid = 1'b1; pad_req = 1'b1;
    step();
    uop_in_valid = 1'b0; pad_req = 1'b0;
    want = {a, b, c, 24'h0};
    @(negedge clk);
    total++;
    if (group_valid !== 1'b1 || group_out !== want || group_count !== CW'(3)) begin
      bad++;
      $display("FAIL pad_with_accept got=%b/%h/%0d exp=1/%h/3", group_valid, group_out, group_count, want);
    end
    step();
  endtask

  task automatic test_flush();
    logic [23:0] u[4];
    logic [24*W-1:0] want;
    clean();
    group_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(24'($urandom));
    flush = 1'b1; uop_in = 24'hABCDEF; uop_in_valid = 1'b1;
    @(negedge clk);
    total++;
    if (uop_in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", uop_in_ready); end
    step();
    flush = 1'b0; uop_in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (group_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", group_valid); end
    group_ready = 1'b1;
    for (int i = 0; i < 4; i++) u[i] = 24'($urandom);
    for (int i = 0; i < 4; i++) send(u[i]);
    want = {u[0], u[1], u[2], u[3]};
    @(negedge clk);
    total++;
    if (group_valid !== 1'b1 || group_out !== want || group_count !== CW'(4)) begin
      bad++;
      $display("FAIL flush_clean got=%b/%h/%0d exp=1/%h/4", group_valid, group_out, group_count, want);
    end
    step();
  endtask

  task automatic test_timeout();
    logic [23:0] a;
    int n;
    bit seen;
    clean();
    group_ready = 1'b1;
    a = 24'($urandom);
    send(a);
    n = 1;
    seen = 1'b0;
`ifdef UOP_PACKER_TIMEOUT_EN
    while (!seen && n <= 40) begin
      @(negedge clk);
      if (group_valid === 1'b1) seen = 1'b1;
      else begin step(); n++; end
    end
    total++;
    if (!seen || n != TO + 1) begin
      bad++;
      $display("FAIL timeout_latency got=%0d seen=%b exp=%0d", n, seen, TO + 1);
    end
    total++;
    if (group_out !== {a, 24'h0, 24'h0, 24'h0} || group_count !== CW'(1)) begin
      bad++;
      $display("FAIL timeout_group got=%h/%0d exp=%h/1", group_out, group_count, {a, 72'h0});
    end
    step();
`else
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (group_valid === 1'b1) seen = 1'b1;
      step();
    end
    total++;
    if (seen) begin bad++; $display("FAIL no_timeout got=group exp=none"); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [23:0] u[4];
    logic [24*W-1:0] want;
    clean();
    group_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(24'($urandom));
    rst = 1'b1;
    step();
    @(negedge clk);
    total++;
    if (group_valid !== 1'b0 || group_out !== '0 || group_count !== '0 || uop_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid got=%b/%h/%0d/%b exp=0/0/0/0", group_valid, group_out, group_count, uop_in_ready);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (uop_in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", uop_in_ready); end
    group_ready = 1'b1;
    for (int i = 0; i < 4; i++) u[i] = 24'($urandom);
    for (int i = 0; i < 4; i++) send(u[i]);
    want = {u[0], u[1], u[2], u[3]};
    @(negedge clk);
    total++;
    if (group_valid !== 1'b1 || group_out !== want || group_count !== CW'(4)) begin
      bad++;
      $display("FAIL rst_mid_refill got=%b/%h/%0d exp=1/%h/4", group_valid, group_out, group_count, want);
    end
    step();
  endtask

  task automatic test_random();
    clean();
    for (int k = 0; k < 3000; k++) begin
      uop_in       = 24'($urandom);
      uop_in_valid = ($urandom_range(0, 9) < 7);
      group_ready  = ($urandom_range(0, 9) < 6);
      pad_req      = ($urandom_range(0, 19) == 0);
      flush        = ($urandom_range(0, 63) == 0);
      step();
    end
    uop_in_valid = 1'b0; pad_req = 1'b0; flush = 1'b0;
    clean();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_pad();
    test_flush();
    test_timeout();
    test_reset_mid();
    test_random();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
